gcn_mem_responder: RTL and testbench

- Memory-side responder for the GCN accelerator. It sits on the other end of the GCN read interfaces (read_address/enable_read -> data_in, coo_address -> coo_in).
- A host preloads the weight rows, feature rows and COO edge list. The block then pulses start, serves GCN reads, and waits for GCN done.
- It replaces the testbench memory model with synthesizable storage and sequencing.

---
 rtl/gcn_mem_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_gcn_mem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_mem_responder.sv
// Memory-side responder for the GCN accelerator: holds host-loaded weight/feature rows and the
// COO edge list, pulses start once everything is loaded, then serves GCN reads until done.
module gcn_mem_responder #(
    parameter int WEIGHT_ROWS     = 96,
    parameter int WEIGHT_WIDTH    = 5,
    parameter int WEIGHT_COLS     = 3,
    parameter int FEATURE_ROWS    = 6,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
    parameter logic [ADDRESS_WIDTH-1:0] WEIGHT_ADDRESS_MIN  = 13'h0000,
    parameter logic [ADDRESS_WIDTH-1:0] FEATURE_ADDRESS_MIN = 13'h0200
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     load_valid,
    output logic                                     load_ready,
    input  logic [ADDRESS_WIDTH-1:0]                 load_addr,
    input  logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] load_data,
    input  logic                                     coo_load_valid,
    input  logic [COO_BW-1:0]                        coo_load_col,
    input  logic [0:1][COO_BW-1:0]                   coo_load_data,
    input  logic                                     enable_read,
    input  logic [ADDRESS_WIDTH-1:0]                 read_address,
    output logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] data_in,
    input  logic [COO_BW-1:0]                        coo_address,
    output logic [0:1][COO_BW-1:0]                   coo_in,
    output logic                                     start,
    input  logic                                     gcn_done,
    input  logic                                     rearm,
    output logic                                     addr_err,
    output logic                                     finished
);

    typedef logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] row_t;
    typedef logic [0:1][COO_BW-1:0] coo_t;
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    row_t weight_mem_r  [WEIGHT_COLS];
    row_t feature_mem_r [FEATURE_ROWS];
    coo_t coo_mem_r     [COO_NUM_OF_COLS];

    logic [WEIGHT_COLS-1:0]     w_mask_r;
    logic [FEATURE_ROWS-1:0]    f_mask_r;
    logic [COO_NUM_OF_COLS-1:0] c_mask_r;

    logic load_ready_r;
    logic start_r;
    logic finished_r;
    logic addr_err_r;
    row_t data_in_r;
    row_t rd_row_s;
    coo_t coo_rd_s;

    logic [ADDRESS_WIDTH-1:0] ld_w_off_s;
    logic [ADDRESS_WIDTH-1:0] ld_f_off_s;
    logic [ADDRESS_WIDTH-1:0] rd_w_off_s;
    logic [ADDRESS_WIDTH-1:0] rd_f_off_s;
    logic ld_w_hit_s;
    logic ld_f_hit_s;
    logic rd_w_hit_s;
    logic rd_f_hit_s;
    logic coo_hit_s;
    logic load_fire_s;
    logic coo_fire_s;
    logic rearm_s;
    logic err_event_s;

    // Unsigned offset subtraction: an address below the region base wraps high and misses.
    assign ld_w_off_s = load_addr - WEIGHT_ADDRESS_MIN;
    assign ld_f_off_s = load_addr - FEATURE_ADDRESS_MIN;
    assign rd_w_off_s = read_address - WEIGHT_ADDRESS_MIN;
    assign rd_f_off_s = read_address - FEATURE_ADDRESS_MIN;
    assign ld_w_hit_s = (ld_w_off_s < ADDRESS_WIDTH'(WEIGHT_COLS));
    assign ld_f_hit_s = (ld_f_off_s < ADDRESS_WIDTH'(FEATURE_ROWS));
    assign rd_w_hit_s = (rd_w_off_s < ADDRESS_WIDTH'(WEIGHT_COLS));
    assign rd_f_hit_s = (rd_f_off_s < ADDRESS_WIDTH'(FEATURE_ROWS));
    assign coo_hit_s  = (32'(coo_load_col) < 32'(COO_NUM_OF_COLS));

    assign load_fire_s = load_valid & load_ready_r;
    assign coo_fire_s  = coo_load_valid & load_ready_r;
    assign rearm_s     = rearm & (state_r == ST_DONE);
    assign err_event_s = (load_fire_s & ~ld_w_hit_s & ~ld_f_hit_s)
                       | (coo_fire_s & ~coo_hit_s)
                       | (enable_read & ~rd_w_hit_s & ~rd_f_hit_s);

    assign load_ready = load_ready_r;
    assign start      = start_r;
    assign finished   = finished_r;
    assign addr_err   = addr_err_r;
    assign data_in    = data_in_r;
    assign coo_in     = coo_rd_s;

    // Row read mux: AND-OR select so an unmapped address yields an all-zero row.
    always_comb begin
        rd_row_s = '0;
        for (int i = 0; i < WEIGHT_COLS; i++) begin
            rd_row_s = rd_row_s | (weight_mem_r[i] &
                       {$bits(row_t){rd_w_hit_s && (rd_w_off_s == ADDRESS_WIDTH'(i))}});
        end
        for (int i = 0; i < FEATURE_ROWS; i++) begin
            rd_row_s = rd_row_s | (feature_mem_r[i] &
                       {$bits(row_t){rd_f_hit_s && (rd_f_off_s == ADDRESS_WIDTH'(i))}});
        end
    end

    // COO column read is combinational; out-of-range columns return zero.
    always_comb begin
        coo_rd_s = '0;
        for (int c = 0; c < COO_NUM_OF_COLS; c++) begin
            coo_rd_s = coo_rd_s | (coo_mem_r[c] & {$bits(coo_t){32'(coo_address) == c}});
        end
    end

    // Row and COO storage writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WEIGHT_COLS; i++)     weight_mem_r[i]  <= '0;
            for (int i = 0; i < FEATURE_ROWS; i++)    feature_mem_r[i] <= '0;
            for (int c = 0; c < COO_NUM_OF_COLS; c++) coo_mem_r[c]     <= '0;
        end else begin
            for (int i = 0; i < WEIGHT_COLS; i++) begin
                if (load_fire_s && ld_w_hit_s && (ld_w_off_s == ADDRESS_WIDTH'(i)))
                    weight_mem_r[i] <= load_data;
            end
            for (int i = 0; i < FEATURE_ROWS; i++) begin
                if (load_fire_s && ld_f_hit_s && (ld_f_off_s == ADDRESS_WIDTH'(i)))
                    feature_mem_r[i] <= load_data;
            end
            for (int c = 0; c < COO_NUM_OF_COLS; c++) begin
                if (coo_fire_s && (32'(coo_load_col) == c))
                    coo_mem_r[c] <= coo_load_data;
            end
        end
    end

    // Registered read port; NBA ordering gives read-before-write on a same-row collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_in_r <= '0;
        end else if (enable_read) begin
            data_in_r <= rd_row_s;
        end
    end

    // Load masks and the sticky address error; a fresh error in the rearm cycle still sticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_mask_r   <= '0;
            f_mask_r   <= '0;
            c_mask_r   <= '0;
            addr_err_r <= 1'b0;
        end else begin
            if (rearm_s) begin
                w_mask_r <= '0;
                f_mask_r <= '0;
                c_mask_r <= '0;
            end else begin
                for (int i = 0; i < WEIGHT_COLS; i++) begin
                    if (load_fire_s && ld_w_hit_s && (ld_w_off_s == ADDRESS_WIDTH'(i)))
                        w_mask_r[i] <= 1'b1;
                end
                for (int i = 0; i < FEATURE_ROWS; i++) begin
                    if (load_fire_s && ld_f_hit_s && (ld_f_off_s == ADDRESS_WIDTH'(i)))
                        f_mask_r[i] <= 1'b1;
                end
                for (int c = 0; c < COO_NUM_OF_COLS; c++) begin
                    if (coo_fire_s && (32'(coo_load_col) == c))
                        c_mask_r[c] <= 1'b1;
                end
            end
            if (err_event_s) begin
                addr_err_r <= 1'b1;
            end else if (rearm_s) begin
                addr_err_r <= 1'b0;
            end
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if ((&w_mask_r) && (&f_mask_r) && (&c_mask_r)) state_nxt_s = ST_ARM;
                else                                           state_nxt_s = ST_LOAD;
            end
            ST_ARM:  state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (gcn_done) state_nxt_s = ST_DONE;
                else          state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (rearm) state_nxt_s = ST_LOAD;
                else       state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_LOAD;
        endcase
    end

    // State register; status outputs are registered from the next state so they track it exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_LOAD;
            load_ready_r <= 1'b1;
            start_r      <= 1'b0;
            finished_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            load_ready_r <= (state_nxt_s == ST_LOAD);
            start_r      <= (state_nxt_s == ST_ARM);
            finished_r   <= (state_nxt_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_gcn_mem_responder.sv
// Directed bench for gcn_mem_responder: table-driven RUN-phase reads plus hand-written
// sequences for load masking, start timing, rearm and asynchronous reset.
module tb_gcn_mem_responder;

    localparam int WR = 96;
    localparam int WW = 5;
    localparam int AW = 13;
    localparam int CB = 3;

    typedef logic [0:WR-1][WW-1:0] row_t;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [CB-1:0] coo;
        logic [WW-1:0] word;
        logic [5:0]    coo_exp;
        logic          err;
    } vec_t;

    logic clk = 1'b0;
    logic reset, load_valid, coo_load_valid, enable_read, gcn_done, rearm;
    logic load_ready, start, addr_err, finished;
    logic [AW-1:0] load_addr, read_address;
    row_t load_data, data_in;
    logic [CB-1:0] coo_load_col, coo_address;
    logic [0:1][CB-1:0] coo_load_data, coo_in;

    int n_pass = 0;
    int n_total = 0;
    int start_cnt = 0;
    vec_t vt [10];

    gcn_mem_responder dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .coo_load_valid(coo_load_valid), .coo_load_col(coo_load_col),
        .coo_load_data(coo_load_data),
        .enable_read(enable_read), .read_address(read_address), .data_in(data_in),
        .coo_address(coo_address), .coo_in(coo_in),
        .start(start), .gcn_done(gcn_done), .rearm(rearm),
        .addr_err(addr_err), .finished(finished)
    );

    always #5 clk = ~clk;

    always @(posedge start) start_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    function automatic row_t fill(input logic [WW-1:0] v);
        row_t r;
        for (int i = 0; i < WR; i++) r[i] = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_row(input logic [AW-1:0] a, input logic [WW-1:0] v);
        load_valid = 1'b1; load_addr = a; load_data = fill(v);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic load_coo(input logic [CB-1:0] c, input logic [5:0] d);
        coo_load_valid = 1'b1; coo_load_col = c; coo_load_data = d;
        tick();
        coo_load_valid = 1'b0;
    endtask

    task automatic load_both(input logic [AW-1:0] a, input logic [WW-1:0] v,
                             input logic [CB-1:0] c, input logic [5:0] d);
        load_valid = 1'b1; load_addr = a; load_data = fill(v);
        coo_load_valid = 1'b1; coo_load_col = c; coo_load_data = d;
        tick();
        load_valid = 1'b0; coo_load_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        enable_read = 1'b1; read_address = a;
        tick();
        enable_read = 1'b0;
    endtask

    initial begin
        reset = 1'b0; load_valid = 1'b0; coo_load_valid = 1'b0; enable_read = 1'b0;
        gcn_done = 1'b0; rearm = 1'b0; load_addr = '0; read_address = '0;
        load_data = fill(5'h00); coo_load_col = '0; coo_load_data = '0; coo_address = '0;

        vt[0] = '{1'b1, 13'h203, 3'd4, 5'h13, 6'o45, 1'b0};
        vt[1] = '{1'b1, 13'h001, 3'd0, 5'h02, 6'o01, 1'b0};
        vt[2] = '{1'b1, 13'h000, 3'd1, 5'h01, 6'o12, 1'b0};
        vt[3] = '{1'b1, 13'h002, 3'd2, 5'h03, 6'o23, 1'b0};
        vt[4] = '{1'b1, 13'h200, 3'd3, 5'h10, 6'o34, 1'b0};
        vt[5] = '{1'b1, 13'h205, 3'd5, 5'h15, 6'o50, 1'b0};
        vt[6] = '{1'b0, 13'h001, 3'd6, 5'h15, 6'o00, 1'b0};
        vt[7] = '{1'b1, 13'h100, 3'd7, 5'h00, 6'o00, 1'b1};
        vt[8] = '{1'b0, 13'h002, 3'd5, 5'h00, 6'o50, 1'b1};
        vt[9] = '{1'b1, 13'h204, 3'd0, 5'h14, 6'o01, 1'b1};

        // Reset state
        tick(); tick();
        chk("rst_load_ready", load_ready, 1'b1);
        chk("rst_start", start, 1'b0);
        chk("rst_finished", finished, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);
        chk("rst_data_in", data_in, fill(5'h00));
        chk("rst_coo_in", coo_in, 6'o00);
        reset = 1'b1;
        tick();

        // Out-of-range COO load flags an error; a reset clears it
        load_coo(3'd7, 6'o77);
        chk("coo7_err", addr_err, 1'b1);
        coo_address = 3'd7; #1;
        chk("coo7_read_zero", coo_in, 6'o00);
        reset = 1'b0; #1;
        chk("err_cleared_by_reset", addr_err, 1'b0);
        tick(); reset = 1'b1; tick();

        // gcn_done / rearm ignored in LOAD
        gcn_done = 1'b1; rearm = 1'b1; tick(); gcn_done = 1'b0; rearm = 1'b0;
        chk("load_done_ignored_fin", finished, 1'b0);
        chk("load_done_ignored_rdy", load_ready, 1'b1);

        // Load everything except feature row 5, with rewrites and paired row+COO loads
        load_both(13'h000, 5'h01, 3'd0, 6'o01);
        load_both(13'h001, 5'h02, 3'd1, 6'o12);
        load_both(13'h002, 5'h03, 3'd2, 6'o23);
        load_both(13'h200, 5'h10, 3'd3, 6'o34);
        load_both(13'h201, 5'h11, 3'd4, 6'o45);
        load_both(13'h202, 5'h12, 3'd5, 6'o50);
        load_row(13'h203, 5'h13);
        load_row(13'h204, 5'h14);
        load_row(13'h001, 5'h1F);
        load_row(13'h001, 5'h02);
        load_row(13'h200, 5'h10);
        repeat (3) tick();
        chk("partial_no_start", start_cnt, 0);
        chk("partial_still_load", load_ready, 1'b1);

        // Final row: start one cycle after masks register, for exactly one cycle
        load_row(13'h205, 5'h15);
        chk("start_not_early", start, 1'b0);
        tick();
        chk("start_pulse", start, 1'b1);
        chk("arm_not_ready", load_ready, 1'b0);
        chk("start_count1", start_cnt, 1);
        tick();
        chk("start_one_cycle", start, 1'b0);
        repeat (3) tick();
        chk("start_no_repeat", start_cnt, 1);
        chk("run_not_ready", load_ready, 1'b0);

        // RUN-phase read table
        for (int k = 0; k < 10; k++) begin
            enable_read = vt[k].en; read_address = vt[k].addr; coo_address = vt[k].coo;
            tick();
            chk($sformatf("vec%0d_data", k), data_in, fill(vt[k].word));
            chk($sformatf("vec%0d_coo", k), coo_in, vt[k].coo_exp);
            chk($sformatf("vec%0d_err", k), addr_err, vt[k].err);
        end
        enable_read = 1'b0;

        // rearm ignored in RUN; gcn_done -> DONE; rearm -> LOAD
        rearm = 1'b1; tick(); rearm = 1'b0;
        chk("run_rearm_ignored_fin", finished, 1'b0);
        chk("run_rearm_ignored_rdy", load_ready, 1'b0);
        gcn_done = 1'b1; tick(); gcn_done = 1'b0;
        chk("done_finished", finished, 1'b1);
        chk("done_err_sticky", addr_err, 1'b1);
        tick();
        chk("done_holds", finished, 1'b1);
        rearm = 1'b1; tick(); rearm = 1'b0;
        chk("rearm_fin", finished, 1'b0);
        chk("rearm_ready", load_ready, 1'b1);
        chk("rearm_err_clr", addr_err, 1'b0);
        chk("rearm_no_start", start_cnt, 1);

        // Storage survives rearm; unmapped loads are dropped
        rd(13'h203);
        chk("kept_after_rearm", data_in, fill(5'h13));
        load_row(13'h206, 5'h1F);
        chk("bad_load_err", addr_err, 1'b1);
        load_coo(3'd7, 6'o77);
        coo_address = 3'd7; #1;
        chk("coo7_not_stored", coo_in, 6'o00);
        coo_address = 3'd1; #1;
        chk("coo1_intact", coo_in, 6'o12);
        rd(13'h205);
        chk("f5_intact", data_in, fill(5'h15));
        rd(13'h200);
        chk("f0_intact", data_in, fill(5'h10));

        // Read-before-write on the same row
        enable_read = 1'b1; read_address = 13'h001;
        load_valid = 1'b1; load_addr = 13'h001; load_data = fill(5'h1E);
        tick();
        load_valid = 1'b0;
        chk("rbw_old", data_in, fill(5'h02));
        tick();
        enable_read = 1'b0;
        chk("rbw_new", data_in, fill(5'h1E));

        // Reload all but COO column 3
        load_both(13'h000, 5'h01, 3'd0, 6'o01);
        load_both(13'h002, 5'h03, 3'd1, 6'o12);
        load_both(13'h200, 5'h10, 3'd2, 6'o23);
        load_both(13'h201, 5'h11, 3'd4, 6'o45);
        load_both(13'h202, 5'h12, 3'd5, 6'o50);
        load_row(13'h203, 5'h13);
        load_row(13'h204, 5'h14);
        load_row(13'h205, 5'h15);
        repeat (3) tick();
        chk("reload_partial_no_start", start_cnt, 1);
        chk("reload_partial_ready", load_ready, 1'b1);
        load_coo(3'd3, 6'o34);
        chk("reload_start_not_early", start, 1'b0);
        tick();
        chk("reload_start", start, 1'b1);
        chk("start_count2", start_cnt, 2);
        tick();

        // Asynchronous reset mid-RUN
        rd(13'h203);
        chk("run2_data", data_in, fill(5'h13));
        #2; reset = 1'b0; #1;
        chk("async_rst_data", data_in, fill(5'h00));
        chk("async_rst_start", start, 1'b0);
        chk("async_rst_ready", load_ready, 1'b1);
        chk("async_rst_fin", finished, 1'b0);
        @(negedge clk); reset = 1'b1;
        tick();
        chk("post_rst_ready", load_ready, 1'b1);
        rd(13'h203);
        chk("post_rst_storage_clr", data_in, fill(5'h00));
        chk("post_rst_err", addr_err, 1'b0);
        repeat (4) tick();
        chk("post_rst_no_start", start_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
